// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2,
        StFlush   = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr_en;
        logic       mem_en;
        logic       mem_wr;
    } shadow_t;

    localparam int unsigned SHADOW_W = $bits(shadow_t);

    function automatic logic is_load(input shadow_t s);
        return s.mem_en & ~s.mem_wr;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_match.sv
// Forwarding select for one ALU operand; EX result beats MEM/WB, x0 never forwarded.
module hz_fwd_match
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       used,
    input  logic [4:0] ex_rd,
    input  logic       ex_wr_en,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_wr_en,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (used && rs != 5'd0) begin
            // A load in EX has no result yet; the load-use stall covers that case.
            if (ex_wr_en && !ex_load && ex_rd == rs) begin
                fwd_sel = FWD_EX;
            end else if (mem_wr_en && mem_rd == rs) begin
                fwd_sel = FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, load-use stalls, branch flushes,
// memory-wait freezes and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1_sel,
    input  logic [4:0]       ID_rs2_sel,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic [4:0]       ID_rd_sel,
    input  logic             ID_wr_en,
    input  logic             ID_mem_en,
    input  logic             ID_mem_wr,
    input  logic             EX_branch_taken,
    input  logic             MEM_ready,
    output logic             PC_stall,
    output logic             IF_stall,
    output logic             IF_flush,
    output logic             ID_bubble,
    output logic             PIPE_freeze,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt
);

    shadow_t   ex_q, mem_q, id_sh;
    hz_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic freeze, load_use, stall_any;

    assign id_sh = '{rd: ID_rd_sel, wr_en: ID_wr_en, mem_en: ID_mem_en, mem_wr: ID_mem_wr};

    assign freeze   = mem_q.mem_en & ~MEM_ready;
    assign load_use = is_load(ex_q) & ex_q.wr_en & (ex_q.rd != 5'd0) &
                      ((ID_rs1_used & (ID_rs1_sel == ex_q.rd)) |
                       (ID_rs2_used & (ID_rs2_sel == ex_q.rd)));

    always_comb begin
        PC_stall    = 1'b0;
        IF_stall    = 1'b0;
        IF_flush    = 1'b0;
        ID_bubble   = 1'b0;
        PIPE_freeze = 1'b0;
        state_d     = StRun;
        if (freeze) begin
            PIPE_freeze = 1'b1;
            PC_stall    = 1'b1;
            IF_stall    = 1'b1;
            state_d     = StMemWait;
        end else if (EX_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use on it is moot.
            IF_flush  = 1'b1;
            ID_bubble = 1'b1;
            state_d   = StFlush;
        end else if (load_use) begin
            PC_stall  = 1'b1;
            IF_stall  = 1'b1;
            ID_bubble = 1'b1;
            state_d   = StLuStall;
        end
    end

    assign stall_any = PC_stall | IF_flush | ID_bubble | PIPE_freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!freeze) begin
                mem_q <= ex_q;
                ex_q  <= ID_bubble ? '0 : id_sh;
            end
            if (stall_any && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    hz_fwd_match u_fwd_rs1 (
        .rs        (ID_rs1_sel),
        .used      (ID_rs1_used),
        .ex_rd     (ex_q.rd),
        .ex_wr_en  (ex_q.wr_en),
        .ex_load   (is_load(ex_q)),
        .mem_rd    (mem_q.rd),
        .mem_wr_en (mem_q.wr_en),
        .fwd_sel   (fwd_rs1_sel)
    );

    hz_fwd_match u_fwd_rs2 (
        .rs        (ID_rs2_sel),
        .used      (ID_rs2_used),
        .ex_rd     (ex_q.rd),
        .ex_wr_en  (ex_q.wr_en),
        .ex_load   (is_load(ex_q)),
        .mem_rd    (mem_q.rd),
        .mem_wr_en (mem_q.wr_en),
        .fwd_sel   (fwd_rs2_sel)
    );

    assign hz_state  = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-instruction expectations queued at
// drive time and compared when the DUT responds.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1_sel, ID_rs2_sel, ID_rd_sel;
    logic        ID_rs1_used, ID_rs2_used, ID_wr_en, ID_mem_en, ID_mem_wr;
    logic        EX_branch_taken, MEM_ready;
    logic        PC_stall, IF_stall, IF_flush, ID_bubble, PIPE_freeze;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel, hz_state;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    typedef struct {
        int         id;
        logic [4:0] flags;   // {PC_stall, IF_stall, IF_flush, ID_bubble, PIPE_freeze}
        logic [1:0] f1;
        logic [1:0] f2;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LDU  = 5'b11010;
    localparam logic [4:0] FRZ  = 5'b11001;
    localparam logic [4:0] BRF  = 5'b00110;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs1_sel      (ID_rs1_sel),
        .ID_rs2_sel      (ID_rs2_sel),
        .ID_rs1_used     (ID_rs1_used),
        .ID_rs2_used     (ID_rs2_used),
        .ID_rd_sel       (ID_rd_sel),
        .ID_wr_en        (ID_wr_en),
        .ID_mem_en       (ID_mem_en),
        .ID_mem_wr       (ID_mem_wr),
        .EX_branch_taken (EX_branch_taken),
        .MEM_ready       (MEM_ready),
        .PC_stall        (PC_stall),
        .IF_stall        (IF_stall),
        .IF_flush        (IF_flush),
        .ID_bubble       (ID_bubble),
        .PIPE_freeze     (PIPE_freeze),
        .fwd_rs1_sel     (fwd_rs1_sel),
        .fwd_rs2_sel     (fwd_rs2_sel),
        .hz_state        (hz_state),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr,
                          input logic men, input logic mwr);
        ID_rs1_sel  = rs1;
        ID_rs1_used = u1;
        ID_rs2_sel  = rs2;
        ID_rs2_used = u2;
        ID_rd_sel   = rd;
        ID_wr_en    = wr;
        ID_mem_en   = men;
        ID_mem_wr   = mwr;
    endtask

    // Called just after a rising edge with the inputs already driven.
    task automatic step(input int id, input logic [4:0] fl, input logic [1:0] f1,
                        input logic [1:0] f2, input logic [1:0] st);
        exp_t e;
        e.id = id; e.flags = fl; e.f1 = f1; e.f2 = f2; e.st = st;
        sb.push_back(e);
        if (fl != 5'b0 && exp_cnt != 65535) exp_cnt++;
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("s%0d_ctl", e.id),
              {27'd0, PC_stall, IF_stall, IF_flush, ID_bubble, PIPE_freeze}, {27'd0, e.flags});
        check($sformatf("s%0d_fwd1", e.id), {30'd0, fwd_rs1_sel}, {30'd0, e.f1});
        check($sformatf("s%0d_fwd2", e.id), {30'd0, fwd_rs2_sel}, {30'd0, e.f2});
        @(posedge clk);
        #1;
        check($sformatf("s%0d_state", e.id), {30'd0, hz_state}, {30'd0, e.st});
        check($sformatf("s%0d_cnt", e.id), {16'd0, stall_cnt}, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        EX_branch_taken = 1'b0;
        MEM_ready = 1'b1;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {27'd0, PC_stall, IF_stall, IF_flush, ID_bubble, PIPE_freeze}, 0);
        check("rst_state", {30'd0, hz_state}, 0);
        check("rst_cnt", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD x5,x1,x2 ; ADD x6,x5,x1 (EX fwd) ; ADD x9,x3,x5 (MEM fwd)
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);  step(1, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);  step(2, NONE, 2'b01, 2'b00, 2'd0);
        set_id(5'd3, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);  step(3, NONE, 2'b00, 2'b10, 2'd0);
        // LW x7 ; ADD x8,x7,x7 stalls once, then gets MEM forwarding
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);  step(4, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);  step(5, LDU,  2'b00, 2'b00, 2'd1);
        step(6, NONE, 2'b10, 2'b10, 2'd0);
        // LW x0 ; ADD x10,x0,x0: no stall, no forwarding
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);  step(7, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); step(8, NONE, 2'b00, 2'b00, 2'd0);
        // SW ; ADD x11 ; then SW in MEM with MEM_ready low for 3 cycles
        set_id(5'd1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);  step(9, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd12, 1'b1, 5'd13, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0); step(10, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd11, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        MEM_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(11 + i, FRZ, 2'b01, 2'b00, 2'd2);
        MEM_ready = 1'b1;
        step(14, NONE, 2'b01, 2'b00, 2'd0);  // EX shadow held through the freeze
        // LW x20 ; ADD x21,x20,x0 with branch taken the same cycle
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0); step(15, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd20, 1'b1, 5'd0, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0);
        EX_branch_taken = 1'b1;
        step(16, BRF, 2'b00, 2'b00, 2'd3);
        EX_branch_taken = 1'b0;
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0); step(17, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);  step(18, NONE, 2'b00, 2'b00, 2'd0);
        set_id(5'd4, 1'b1, 5'd5, 1'b1, 5'd23, 1'b1, 1'b0, 1'b0); step(19, NONE, 2'b00, 2'b00, 2'd0);
        MEM_ready = 1'b0;
        step(20, FRZ, 2'b00, 2'b00, 2'd2);

        // Hold the freeze long enough to saturate the counter.
        repeat (65540) @(posedge clk);
        #1;
        check("sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat_frz", {31'd0, PIPE_freeze}, 1);
        @(posedge clk);
        #1;
        check("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Asynchronous reset mid-freeze.
        #2 rst = 1'b1;
        #1;
        check("rstf_ctl", {27'd0, PC_stall, IF_stall, IF_flush, ID_bubble, PIPE_freeze}, 0);
        check("rstf_fwd", {28'd0, fwd_rs1_sel, fwd_rs2_sel}, 0);
        check("rstf_state", {30'd0, hz_state}, 0);
        check("rstf_cnt", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage RISC-V pipeline. Shadows the destination/control fields of the instructions in EX and MEM, and from the decoded ID-stage instruction produces forwarding selects, load-use stalls with bubble insertion, branch flushes and whole-pipe freezes while data memory is not ready. Drives the enable/bubble controls of the IF/ID and ID/EX pipeline registers and the operand-forwarding muxes at the ALU inputs. Keeps a saturating stall-cycle counter for performance checks.

## Interface
- `CNT_W`, 16, width of stall-cycle counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ID_rs1_sel`, `ID_rs2_sel`  in  5  source register indices of the ID instruction
- `ID_rs1_used`, `ID_rs2_used`  in  1  ID instruction actually reads rs1/rs2
- `ID_rd_sel`  in  5  destination of the ID instruction
- `ID_wr_en`, `ID_mem_en`, `ID_mem_wr`  in  1  ID control bits (reg write, memory access, memory write)
- `EX_branch_taken`  in  1  branch/jump in EX resolved taken this cycle
- `MEM_ready`  in  1  data memory completes the access in MEM this cycle
- `PC_stall`  out  1  hold PC
- `IF_stall`  out  1  hold IF/ID register
- `IF_flush`  out  1  load NOP into IF/ID
- `ID_bubble`  out  1  load zeroed control (wr_en=mem_en=mem_wr=0) into ID/EX
- `PIPE_freeze`  out  1  hold every pipeline register including EX/MEM and MEM/WB
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  2  00 register file, 01 EX result, 10 MEM/WB value
- `hz_state`  out  2  FSM state (for debug/bench)
- `stall_cnt`  out  CNT_W  cycles with any stall, freeze or bubble

## Operation
- Shadow entries EXs and MEMs each hold {rd, wr_en, mem_en, mem_wr}; reset clears all to 0.
- Each clock with PIPE_freeze=0: MEMs <= EXs; EXs <= ID_bubble ? zero : ID fields. With PIPE_freeze=1 both hold.
- Freeze: PIPE_freeze = MEMs.mem_en & ~MEM_ready. Also asserts PC_stall, IF_stall; ID_bubble and IF_flush forced 0. Highest priority.
- Branch (no freeze): EX_branch_taken -> IF_flush=1, ID_bubble=1, PC_stall=0. Overrides load-use (ID instruction is wrong-path).
- Load-use (no freeze, no branch): EXs.mem_en & ~EXs.mem_wr & EXs.wr_en & EXs.rd!=0 and (rs1_used & rs1==EXs.rd or rs2_used & rs2==EXs.rd) -> PC_stall=1, IF_stall=1, ID_bubble=1.
- Forwarding per operand: EX match (EXs.wr_en, rd!=0, equal, not a load) -> 01; else MEM match (MEMs.wr_en, rd!=0, equal) -> 10; else 00. EX beats MEM. x0 never forwarded. Unused operand -> 00.
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3. Next state: freeze -> MEM_WAIT; else branch -> FLUSH; else load-use -> LU_STALL; else RUN. LU_STALL and FLUSH last one cycle unless re-triggered.
- stall_cnt increments when any of PC_stall, IF_flush, ID_bubble, PIPE_freeze is 1; saturates at all-ones.

## Timing
- All hazard outputs combinational from current inputs and registered shadow; same-cycle effect at the pipeline-register enables.
- Load-use costs exactly 1 bubble; next cycle the load is in MEMs and the consumer gets fwd 10.
- Taken branch costs 2 squashed instructions (IF/ID and ID/EX).
- Reset values: all stall/flush/bubble/freeze 0, fwd 00, hz_state RUN, stall_cnt 0. Reset mid-freeze drops freeze immediately (shadow cleared).
- MEM_ready high while MEMs.mem_en=0 is ignored.

## Structure
- Shared package: FSM state encodings, fwd select encodings (FWD_RF, FWD_EX, FWD_MEM), shadow-entry struct width.
- One sub-module natural: `hz_fwd_match` (one operand's forwarding compare), instantiated twice.

## Test plan
- Back-to-back ADD x5 then ADD x6,x5,x1 -> fwd_rs1_sel=01, no stall; one instr later x5 reader -> 10.
- LW x7 then ADD x8,x7,x7 -> one cycle PC_stall=IF_stall=ID_bubble=1, hz_state=1, then fwd_rs1/rs2=10, stall_cnt=1.
- Load into x0 followed by reader of x0 -> no stall, fwd 00.
- SW in MEM with MEM_ready low 3 cycles -> PIPE_freeze=1 for 3 cycles, shadows held, hz_state=2, stall_cnt=3.
- EX_branch_taken with load-use present in the same cycle -> IF_flush=1, ID_bubble=1, PC_stall=0, hz_state=3.
- Assert rst during freeze -> all outputs 0/RUN next instant, stall_cnt=0; counter preset to 0xFFFF stays 0xFFFF on further stalls.
